// File: rtl/minicpu_multicycle_pkg.sv
// minicpu_multicycle_pkg: shared FSM encodings, trap causes and instruction decoder for the multi-cycle core
// No ports; imported by minicpu_multicycle.
package minicpu_multicycle_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_ILL  = 2'd1;
    localparam logic [1:0] CAUSE_IBUS = 2'd2;
    localparam logic [1:0] CAUSE_DBUS = 2'd3;

    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_ADDI, OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_ILL} op_e;

    function automatic op_e decode(input logic [31:0] ir);
        return ir[31:15] == 17'h00020 ? OP_ADD  :
               ir[31:15] == 17'h00022 ? OP_SUB  :
               ir[31:22] == 10'h00a   ? OP_ADDI :
               ir[31:22] == 10'h0a2   ? OP_LD   :
               ir[31:22] == 10'h0a6   ? OP_ST   :
               ir[31:26] == 6'h16     ? OP_BEQ  :
               ir[31:26] == 6'h17     ? OP_BNE  : OP_ILL;
    endfunction

endpackage

// File: rtl/minicpu_multicycle_regfile.sv
// minicpu_multicycle_regfile: 32x32 register file, two async read ports, one sync write port, r0 reads 0
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr1_i/rdata1_o and raddr2_i/rdata2_o read ports.
module minicpu_multicycle_regfile (
    input  logic        clk,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o
);

    logic [31:0] rf_q [32];

    always_ff @(posedge clk)
        if (we_i && waddr_i != 5'd0) rf_q[waddr_i] <= wdata_i;

    assign rdata1_o = raddr1_i == 5'd0 ? 32'd0 : rf_q[raddr1_i];
    assign rdata2_o = raddr2_i == 5'd0 ? 32'd0 : rf_q[raddr2_i];

endmodule

// File: rtl/minicpu_multicycle.sv
// minicpu_multicycle: multi-cycle LA32R mini core on req/ack memory buses with traps and a retire counter
// Ports:
//   clk, resetn                              clock, asynchronous active-low reset
//   inst_req/inst_addr/inst_ack/inst_rdata   instruction fetch handshake
//   data_req/data_we/data_addr/data_wdata/data_ack/data_rdata   load/store handshake
//   trap, trap_cause                         sticky halt flag and its reason
//   retired, wb_pc                           retired-instruction count, pc of last retired instruction
module minicpu_multicycle
    import minicpu_multicycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int          WDOG_W     = 8,
    parameter int          PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  inst_req,
    output logic [31:0]           inst_addr,
    input  logic                  inst_ack,
    input  logic [31:0]           inst_rdata,
    output logic                  data_req,
    output logic                  data_we,
    output logic [31:0]           data_addr,
    output logic [31:0]           data_wdata,
    input  logic                  data_ack,
    input  logic [31:0]           data_rdata,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [PERF_CNT_W-1:0] retired,
    output logic [31:0]           wb_pc
);

    // The cycle that would bring the watchdog to all-ones is the one that traps.
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [2:0]            state_q, state_d;
    logic [1:0]            cause_q, cause_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic [PERF_CNT_W-1:0] retired_q;
    logic [31:0]           pc_q, wb_pc_q, ir_q, mdr_q, a_q, b_q, alu_q;
    logic [31:0]           rs1, rs2, si12, offs;
    logic                  taken_q;
    op_e                   op;

    assign op   = decode(ir_q);
    assign si12 = {{20{ir_q[21]}}, ir_q[21:10]};
    assign offs = {{14{ir_q[25]}}, ir_q[25:10], 2'b00};

    // Stores and branches take their second operand from the rd field.
    minicpu_multicycle_regfile u_rf (
        .clk      (clk),
        .we_i     (state_q == S_WB && op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LD}),
        .waddr_i  (ir_q[4:0]),
        .wdata_i  (op == OP_LD ? mdr_q : alu_q),
        .raddr1_i (ir_q[9:5]),
        .rdata1_o (rs1),
        .raddr2_i (op inside {OP_ST, OP_BEQ, OP_BNE} ? ir_q[4:0] : ir_q[14:10]),
        .rdata2_o (rs2)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        wdog_d  = '0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:
                if (inst_ack) state_d = S_DECODE;
                else if (wdog_q == WDOG_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IBUS;
                end else wdog_d = wdog_q + WDOG_W'(1);
            S_DECODE: begin
                state_d = op == OP_ILL ? S_TRAP : S_EXEC;
                cause_d = op == OP_ILL ? CAUSE_ILL : cause_q;
            end
            S_EXEC:   state_d = op inside {OP_LD, OP_ST} ? S_MEM : S_WB;
            S_MEM:
                if (data_ack) state_d = S_WB;
                else if (wdog_q == WDOG_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DBUS;
                end else wdog_d = wdog_q + WDOG_W'(1);
            S_WB:     state_d = S_FETCH;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cause_q   <= CAUSE_NONE;
            wdog_q    <= '0;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            wb_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wdog_q  <= wdog_d;
            if (state_q == S_WB) begin
                pc_q      <= taken_q ? pc_q + offs : pc_q + 32'd4;
                retired_q <= retired_q + PERF_CNT_W'(1);
                wb_pc_q   <= pc_q;
            end
        end
    end

    // Datapath latches carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH && inst_ack) ir_q <= inst_rdata;
        if (state_q == S_MEM && data_ack) mdr_q <= data_rdata;
        if (state_q == S_DECODE) begin
            a_q <= rs1;
            b_q <= rs2;
        end
        if (state_q == S_EXEC) begin
            alu_q   <= op == OP_ADD ? a_q + b_q : op == OP_SUB ? a_q - b_q : a_q + si12;
            taken_q <= op == OP_BEQ ? a_q == b_q : op == OP_BNE && a_q != b_q;
        end
    end

    assign inst_req   = state_q == S_FETCH;
    assign inst_addr  = pc_q;
    assign data_req   = state_q == S_MEM;
    assign data_we    = op == OP_ST;
    assign data_addr  = alu_q;
    assign data_wdata = b_q;
    assign trap       = state_q == S_TRAP;
    assign trap_cause = cause_q;
    assign retired    = retired_q;
    assign wb_pc      = wb_pc_q;

endmodule

// File: tb/tb_minicpu_multicycle.sv
// tb_minicpu_multicycle: directed plus random-program bench for minicpu_multicycle against an ISA-level model
module tb_minicpu_multicycle;

    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam logic [16:0] ADDW   = 17'h00020;
    localparam logic [16:0] SUBW   = 17'h00022;
    localparam logic [9:0]  ADDIW  = 10'h00a;
    localparam logic [9:0]  LDW    = 10'h0a2;
    localparam logic [9:0]  STW    = 10'h0a6;
    localparam logic [5:0]  BEQ    = 6'h16;
    localparam logic [5:0]  BNE    = 6'h17;

    logic        clk = 1'b0, resetn = 1'b0, inst_ack = 1'b0, data_ack = 1'b0;
    logic [31:0] inst_rdata = '0, data_rdata = '0;
    logic        inst_req, data_req, data_we, trap;
    logic [31:0] inst_addr, data_addr, data_wdata, retired, wb_pc;
    logic [1:0]  trap_cause;

    int n_chk = 0, n_fail = 0;

    // Architectural model: register values, pc, retire count, last retired pc, data memory.
    logic [31:0] mr [32];
    logic [31:0] m_pc, m_ret, m_wbpc;
    logic [31:0] dmem [logic [31:0]];

    always #5 clk = ~clk;

    minicpu_multicycle #(.RESET_PC(RST_PC), .WDOG_W(3), .PERF_CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata),
        .trap(trap), .trap_cause(trap_cause), .retired(retired), .wb_pc(wb_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [16:0] op, input logic [4:0] rd, rj, rk);
        return {op, rk, rj, rd};
    endfunction

    function automatic logic [31:0] ri(input logic [9:0] op, input logic [4:0] rd, rj, input logic [11:0] imm);
        return {op, imm, rj, rd};
    endfunction

    function automatic logic [31:0] rb(input logic [5:0] op, input logic [4:0] rj, rd, input int off);
        return {op, 16'(off >>> 2), rj, rd};
    endfunction

    function automatic logic [31:0] gen();
        int k = $urandom_range(0, 6);
        logic [4:0] rd = 5'($urandom), rj = 5'($urandom), rk = 5'($urandom);
        logic [11:0] imm = 12'($urandom);
        int off = ($urandom_range(0, 64) - 32) * 4;
        if (k >= 5 && $urandom_range(0, 1) == 1) rd = rj;
        case (k)
            0: return rr(ADDW, rd, rj, rk);
            1: return rr(SUBW, rd, rj, rk);
            2: return ri(ADDIW, rd, rj, imm);
            3: return ri(LDW, rd, rj, imm);
            4: return ri(STW, rd, rj, imm);
            5: return rb(BEQ, rj, rd, off);
            default: return rb(BNE, rj, rd, off);
        endcase
    endfunction

    task automatic spurious();
        inst_ack = 1'($urandom);
        data_ack = 1'($urandom);
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        chk("rst_inst_req", inst_req, 0);
        chk("rst_data_req", data_req, 0);
        chk("rst_trap", trap, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_retired", retired, 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_pc", inst_addr, RST_PC);
        inst_ack = 1'b1;
        data_ack = 1'b1;
        @(negedge clk);
        inst_ack = 1'b0;
        data_ack = 1'b0;
        resetn = 1'b1;
        m_pc = RST_PC;
        m_ret = 0;
        m_wbpc = 0;
        #1 chk("idle_req", inst_req, 0);
        @(negedge clk);
    endtask

    task automatic expect_trap(input logic [1:0] c);
        chk("trap", trap, 1);
        chk("trap_cause", trap_cause, c);
        chk("trap_inst_req", inst_req, 0);
        chk("trap_data_req", data_req, 0);
        inst_ack = 1'b1;
        data_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("trap_held", trap, 1);
        chk("trap_cause_held", trap_cause, c);
        chk("trap_req_held", inst_req, 0);
        chk("trap_pc", inst_addr, m_pc);
        chk("trap_retired", retired, m_ret);
        chk("trap_wb_pc", wb_pc, m_wbpc);
        inst_ack = 1'b0;
        data_ack = 1'b0;
    endtask

    // Runs one instruction from a negedge in FETCH to the negedge in the next FETCH.
    // iw/dw are wait cycles before ack; 7 or more waits must trip the watchdog.
    task automatic exec_one(input logic [31:0] w, input int iw, input int dw, input bit rst_mem = 1'b0);
        logic [4:0]  rd, rj, rk;
        logic [31:0] sext, boff, addr, res, npc;
        bit legal, mem, st, wr;
        rd = w[4:0]; rj = w[9:5]; rk = w[14:10];
        sext = {{20{w[21]}}, w[21:10]};
        boff = {{14{w[25]}}, w[25:10], 2'b00};
        legal = 1; mem = 0; st = 0; wr = 1; res = 0;
        npc = m_pc + 4;
        addr = mr[rj] + sext;
        if (w[31:15] == ADDW) res = mr[rj] + mr[rk];
        else if (w[31:15] == SUBW) res = mr[rj] - mr[rk];
        else if (w[31:22] == ADDIW) res = addr;
        else if (w[31:22] == LDW) begin
            mem = 1;
            if (!dmem.exists(addr)) dmem[addr] = $urandom;
            res = dmem[addr];
        end else if (w[31:22] == STW) begin
            mem = 1; st = 1; wr = 0;
        end else if (w[31:26] == BEQ) begin
            wr = 0;
            if (mr[rj] == mr[rd]) npc = m_pc + boff;
        end else if (w[31:26] == BNE) begin
            wr = 0;
            if (mr[rj] != mr[rd]) npc = m_pc + boff;
        end else legal = 0;
        inst_ack = 1'b0;
        data_ack = 1'b0;
        chk("inst_req", inst_req, 1);
        chk("inst_addr", inst_addr, m_pc);
        for (int i = 0; i < iw; i++) begin
            @(negedge clk);
            if (i == 6) begin
                expect_trap(2'd2);
                return;
            end
            chk("inst_req_wait", inst_req, 1);
            chk("inst_addr_hold", inst_addr, m_pc);
        end
        inst_ack = 1'b1;
        inst_rdata = w;
        @(negedge clk);
        inst_rdata = $urandom;
        spurious();
        chk("inst_req_drop", inst_req, 0);
        @(negedge clk);
        if (!legal) begin
            expect_trap(2'd1);
            return;
        end
        spurious();
        chk("trap_run", trap, 0);
        @(negedge clk);
        if (mem) begin
            inst_ack = 1'b0;
            data_ack = 1'b0;
            chk("data_req", data_req, 1);
            chk("data_we", data_we, st);
            chk("data_addr", data_addr, addr);
            if (st) chk("data_wdata", data_wdata, mr[rd]);
            if (rst_mem) begin
                do_reset();
                return;
            end
            for (int i = 0; i < dw; i++) begin
                @(negedge clk);
                if (i == 6) begin
                    expect_trap(2'd3);
                    return;
                end
                chk("data_req_wait", data_req, 1);
                chk("data_addr_hold", data_addr, addr);
                if (st) chk("data_wdata_hold", data_wdata, mr[rd]);
            end
            data_ack = 1'b1;
            data_rdata = st ? $urandom : res;
            @(negedge clk);
            data_rdata = $urandom;
            spurious();
        end else spurious();
        chk("wb_data_req", data_req, 0);
        chk("wb_retired_pending", retired, m_ret);
        if (st) dmem[addr] = mr[rd];
        if (wr && rd != 0) mr[rd] = res;
        m_wbpc = m_pc;
        m_pc = npc;
        m_ret++;
        @(negedge clk);
        inst_ack = 1'b0;
        data_ack = 1'b0;
        chk("retired", retired, m_ret);
        chk("wb_pc", wb_pc, m_wbpc);
        chk("next_pc", inst_addr, m_pc);
    endtask

    initial begin
        mr[0] = 0;
        @(negedge clk);
        do_reset();
        exec_one(ri(ADDIW, 1, 0, 12'd5), 0, 0);
        exec_one(rr(ADDW, 2, 1, 1), 0, 0);
        chk("retired_two", retired, 2);
        chk("wb_pc_second", wb_pc, RST_PC + 4);
        exec_one(ri(STW, 2, 0, 12'h100), 0, 3);
        exec_one(ri(LDW, 3, 0, 12'h100), 3, 3);
        exec_one(ri(STW, 3, 0, 12'h104), 1, 0);
        exec_one(rb(BNE, 1, 2, -8), 0, 0);
        exec_one(rb(BEQ, 2, 3, 12), 2, 0);
        exec_one(rb(BNE, 2, 3, 12), 0, 0);
        exec_one(rb(BEQ, 1, 2, 16), 0, 0);
        exec_one(rr(SUBW, 4, 1, 2), 0, 0);
        for (int i = 5; i < 32; i++) exec_one(ri(ADDIW, 5'(i), 0, 12'($urandom)), 0, 0);
        for (int n = 0; n < 300; n++) exec_one(gen(), $urandom_range(0, 6), $urandom_range(0, 6));
        for (int i = 0; i < 32; i++) exec_one(ri(STW, 5'(i), 0, 12'(i * 4)), 0, 0);
        exec_one(ri(STW, 5, 0, 12'h40), 0, 0, 1'b1);
        exec_one(ri(ADDIW, 0, 0, 12'd1), 0, 0);
        exec_one(ri(STW, 0, 0, 12'h200), 0, 0);
        exec_one(ri(ADDIW, 1, 0, 12'd1), 7, 0);
        do_reset();
        exec_one(ri(LDW, 6, 0, 12'h80), 1, 7);
        do_reset();
        exec_one(ri(ADDIW, 7, 0, 12'd9), 0, 0);
        exec_one(32'hffffffff, 2, 0);
        do_reset();
        exec_one(ri(STW, 7, 0, 12'h10), 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
